// File: rtl/axis_wrr_frame_sched.sv
// Frame-granular weighted round-robin grant generator for an AXI-stream mux.
// Grant is registered, held for one whole frame, and credits are spent one per frame.
module axis_wrr_frame_sched #(
    parameter int S_COUNT      = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CL_S_COUNT   = $clog2(S_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [S_COUNT-1:0]              req,
    input  logic [S_COUNT*WEIGHT_WIDTH-1:0] weight,
    input  logic                            cfg_load,
    input  logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    input  logic                            m_axis_tlast,
    output logic [S_COUNT-1:0]              grant,
    output logic                            grant_valid,
    output logic [CL_S_COUNT-1:0]           grant_encoded,
    output logic                            round_done
);

    localparam int IW = CL_S_COUNT + 1;

    typedef enum logic {ARB, BUSY} state_e;

    state_e                                 state_q, state_d;
    logic [CL_S_COUNT-1:0]                  ptr_q, ptr_d;
    logic [S_COUNT-1:0][WEIGHT_WIDTH-1:0]   credit_q, credit_d;
    logic                                   load_pend_q, load_pend_d;
    logic [S_COUNT-1:0]                     grant_q, grant_d;
    logic                                   gv_q, gv_d;
    logic [CL_S_COUNT-1:0]                  enc_q, enc_d;
    logic                                   rd_q, rd_d;

    logic [S_COUNT-1:0][WEIGHT_WIDTH-1:0]   w_arr;
    logic [S_COUNT-1:0]                     elig, w_nz;
    logic [CL_S_COUNT-1:0]                  sel;
    logic [IW-1:0]                          idx;
    logic                                   last_hs;

    assign w_arr   = weight;
    assign last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        for (int i = 0; i < S_COUNT; i++) begin
            elig[i] = req[i] & (credit_q[i] != '0);
            w_nz[i] = (w_arr[i] != '0);
        end
    end

    // Scan from the farthest offset down so the closest eligible index to ptr wins.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + IW'(k);
            if (idx >= IW'(S_COUNT))
                idx = idx - IW'(S_COUNT);
            if (elig[idx[CL_S_COUNT-1:0]])
                sel = idx[CL_S_COUNT-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        credit_d    = credit_q;
        load_pend_d = load_pend_q | cfg_load;
        grant_d     = grant_q;
        gv_d        = gv_q;
        enc_d       = enc_q;
        rd_d        = 1'b0;
        case (state_q)
            ARB: begin
                if (load_pend_q) begin
                    credit_d    = w_arr;
                    load_pend_d = cfg_load;
                    rd_d        = 1'b1;
                end else if (|elig) begin
                    grant_d = {{(S_COUNT-1){1'b0}}, 1'b1} << sel;
                    gv_d    = 1'b1;
                    enc_d   = sel;
                    ptr_d   = sel;
                    state_d = BUSY;
                end else if (|(req & w_nz)) begin
                    credit_d = w_arr;
                    rd_d     = 1'b1;
                end
            end
            BUSY: begin
                if (last_hs) begin
                    credit_d[enc_q] = credit_q[enc_q] - 1'b1;
                    grant_d = '0;
                    gv_d    = 1'b0;
                    enc_d   = '0;
                    state_d = ARB;
                    // Last credit spent: move on so the next port leads the scan.
                    if (credit_q[enc_q] == WEIGHT_WIDTH'(1))
                        ptr_d = (enc_q == CL_S_COUNT'(S_COUNT - 1)) ? '0 : enc_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            credit_q    <= '0;
            load_pend_q <= 1'b0;
            grant_q     <= '0;
            gv_q        <= 1'b0;
            enc_q       <= '0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            load_pend_q <= load_pend_d;
            grant_q     <= grant_d;
            gv_q        <= gv_d;
            enc_q       <= enc_d;
            rd_q        <= rd_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = gv_q;
    assign grant_encoded = enc_q;
    assign round_done    = rd_q;

endmodule

// File: tb/tb_axis_wrr_frame_sched.sv
// Directed bench for axis_wrr_frame_sched: grant order, weights, holds and reloads.
module tb_axis_wrr_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        cfg_load;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_encoded;
    logic        round_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] ev [$];

    localparam logic [4:0] R = 5'h10;

    axis_wrr_frame_sched #(.S_COUNT(4), .WEIGHT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .weight(weight), .cfg_load(cfg_load),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .grant(grant), .grant_valid(grant_valid),
        .grant_encoded(grant_encoded), .round_done(round_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record one event per cycle: round_done pulse or the active one-hot grant.
    task automatic collect(input int ncyc);
        ev.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (round_done) ev.push_back(R);
            else if (grant_valid) ev.push_back({1'b0, grant});
        end
    endtask

    function automatic logic [4:0] get_ev(input int i);
        return (i < ev.size()) ? ev[i] : 5'h1F;
    endfunction

    task automatic do_reset(input logic [3:0] r, input logic [15:0] w, input logic beats_on);
        rst_n = 1'b0;
        req = 4'b0; weight = w; cfg_load = 1'b0;
        m_axis_tvalid = beats_on; m_axis_tready = beats_on; m_axis_tlast = beats_on;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", {28'b0, grant}, 32'h0);
        chk("rst_gv_rd", {30'b0, grant_valid, round_done}, 32'h0);
        rst_n = 1'b1;
        req = r;
    endtask

    initial begin
        logic [4:0] e2 [11] = '{R, 5'h1, 5'h2, 5'h4, 5'h8, R, 5'h1, 5'h2, 5'h4, 5'h8, R};
        logic [4:0] e3 [9]  = '{R, 5'h1, 5'h1, 5'h1, 5'h2, 5'h8, 5'h8, R, 5'h1};
        logic [4:0] e6 [6]  = '{R, 5'h1, 5'h2, R, 5'h1, 5'h2};
        logic [9:0] gv_bits, rd_bits;
        int beats;
        logic ph;

        // 1: async reset mid-frame, then reload + grant latency
        do_reset(4'b0010, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_pre_grant", {28'b0, grant}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_grant", {28'b0, grant}, 32'h0);
        chk("t1_async_gv_rd", {30'b0, grant_valid, round_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        chk("t1_rd_c1", {31'b0, round_done}, 32'h1);
        chk("t1_grant_c1", {28'b0, grant}, 32'h0);
        @(negedge clk);
        chk("t1_grant_c2", {28'b0, grant}, 32'h1);
        chk("t1_rd_c2", {31'b0, round_done}, 32'h0);

        // 2: equal weights, plain round robin
        do_reset(4'b1111, 16'h1111, 1'b1);
        collect(20);
        for (int i = 0; i < 11; i++) chk($sformatf("t2_ev%0d", i), {27'b0, get_ev(i)}, {27'b0, e2[i]});

        // 3: weights w0=3 w1=1 w2=0 w3=2
        do_reset(4'b1111, 16'h2013, 1'b1);
        collect(16);
        for (int i = 0; i < 9; i++) chk($sformatf("t3_ev%0d", i), {27'b0, get_ev(i)}, {27'b0, e3[i]});

        // 4: 5-beat frame on port 1 with tready toggling; req drops mid-frame
        do_reset(4'b0010, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_start", {28'b0, grant}, 32'h2);
        beats = 0;
        ph = 1'b1;
        for (int c = 0; c < 20 && beats < 5; c++) begin
            m_axis_tvalid = 1'b1;
            m_axis_tready = ph;
            m_axis_tlast  = (beats == 4);
            if (beats == 2) req = 4'b0000;
            @(negedge clk);
            if (ph) beats++;
            ph = ~ph;
            if (beats < 5) chk($sformatf("t4_hold%0d", c), {28'b0, grant}, 32'h2);
            else chk("t4_drop", {28'b0, grant}, 32'h0);
        end
        chk("t4_beats", beats, 5);
        m_axis_tvalid = 1'b0;

        // 5: lone requester, weight 2: reload costs an extra idle cycle
        do_reset(4'b0100, 16'h1211, 1'b1);
        gv_bits = '0;
        rd_bits = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            gv_bits = {gv_bits[8:0], grant_valid};
            rd_bits = {rd_bits[8:0], round_done};
            if (c == 1) chk("t5_enc", {30'b0, grant_encoded}, 32'h2);
        end
        chk("t5_gv_pattern", {22'b0, gv_bits}, {22'b0, 10'b0101001010});
        chk("t5_rd_pattern", {22'b0, rd_bits}, {22'b0, 10'b1000010000});

        // 6: cfg_load during a frame, w0 3 -> 1
        do_reset(4'b0011, 16'h1113, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_start", {28'b0, grant}, 32'h1);
        cfg_load = 1'b1;
        weight = 16'h1111;
        @(negedge clk);
        cfg_load = 1'b0;
        chk("t6_held", {28'b0, grant}, 32'h1);
        m_axis_tvalid = 1'b1; m_axis_tready = 1'b1; m_axis_tlast = 1'b1;
        collect(10);
        for (int i = 0; i < 6; i++) chk($sformatf("t6_ev%0d", i), {27'b0, get_ev(i)}, {27'b0, e6[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
